fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage LoongArch pipeline: owns the PC, issues reads to the synchronous instruction SRAM, and presents {inst, pc} to the ID stage. It sits directly upstream of ID and consumes the hazard block's outputs. `block_if` freezes fetch. `br_stall` marks the ID-stage branch decision as not yet trustworthy. It also buffers the SRAM read data across stalls and discards wrong-path instructions on a taken branch.

## Interface
- `RESET_PC`, default 32'h1c000000: first fetch address after reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  reset is synchronous and active-low.
- `ds_allowin`  in  1  ID can accept an instruction this cycle.
- `block_if`  in  1  stall from the hazard block; the current IF instruction must not advance.
- `br_stall`  in  1  the ID branch has unresolved operands; ignore `br_taken`.
- `br_taken`  in  1  the ID-stage branch or jump is taken.
- `br_target`  in  32  branch target address.
- `fs_to_ds_valid`  out  1  `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus`  out  64  {inst[63:32], pc[31:0]}.
- `inst_sram_en`  out  1  read enable.
- `inst_sram_we`  out  4  always 4'b0.
- `inst_sram_addr`  out  32  read address (= nextpc).
- `inst_sram_wdata`  out  32  always 32'b0.
- `inst_sram_rdata`  in  32  read data, valid the cycle after the enabled read.

## Operation
- State:
  - `fs_valid`
  - `fs_pc` (32 bits)
  - `inst_buf` (32 bits)
  - `inst_buf_valid`
- Redirect: `redirect = br_taken && !br_stall && ds_allowin`.
  - `redirect` is accepted only in the cycle the branch leaves ID.
  - This gives one redirect per branch, even if `br_taken` is held high for several cycles.
- Next PC:
  - `nextpc = redirect ? br_target : (fs_pc + 4)`.
  - The addition is modulo 2^32.
  - While resetn is low, `fs_pc` is loaded with `RESET_PC - 4`, so the first `nextpc` is `RESET_PC`.
- Allow-in: `fs_allowin = !fs_valid || redirect || (ds_allowin && !block_if)`.
- SRAM port:
  - `inst_sram_en = resetn && fs_allowin`.
  - `inst_sram_addr = nextpc`.
- IF register: when `fs_allowin` and resetn is high, `fs_valid <= 1` and `fs_pc <= nextpc`.
- Instruction select: `inst = inst_buf_valid ? inst_buf : inst_sram_rdata`.
- Read-data buffer:
  - Set: if `fs_valid && !inst_buf_valid && !fs_allowin`, then `inst_buf <= inst_sram_rdata` and `inst_buf_valid <= 1`. This captures the data in the first stalled cycle.
  - Clear: `inst_buf_valid <= 0` whenever `fs_allowin`. The clear takes priority over the set.
- Output valid: `fs_to_ds_valid = fs_valid && !redirect && !block_if`. The wrong-path instruction held in IF during a redirect is dropped, never forwarded.
- No other output depends on `br_stall`. While `br_stall` is high, `block_if` is also high, so IF holds.

## Timing
- Reset values while resetn is low:
  - `fs_valid = 0`
  - `inst_buf_valid = 0`
  - `inst_buf = 0`
  - `fs_pc = RESET_PC - 4`
  - `fs_to_ds_valid = 0`
  - `inst_sram_en = 0`
- First fetch:
  - Cycle 0 (first cycle with resetn high): `en = 1`, `addr = RESET_PC`.
  - Cycle 1: `fs_valid = 1`, `pc = RESET_PC`, inst comes from rdata.
- Throughput: one instruction per cycle when unstalled. SRAM latency is 1 cycle and is fully hidden.
- Stall: while stalled, `en = 0` and pc/inst are held. `inst` comes from `inst_buf` starting in the second stalled cycle.
- Branch penalty: one bubble. The target instruction is in IF the cycle after `redirect`.
- Simultaneous events:
  - `redirect` with `block_if = 1`: the redirect still applies. The IF instruction is squashed and IF reloads with the target.
  - `br_taken` with `br_stall = 1`: ignored.
  - `br_taken` with `ds_allowin = 0`: deferred until `ds_allowin` goes high.
- Reset mid-stream: taking effect at the next edge, all state returns to its reset value and any buffered instruction is lost.

## Test plan
- Reset release:
  - Stimulus: resetn high, `ds_allowin = 1`, `block_if = 0`.
  - Required: addr sequence 1c000000, 1c000004, 1c000008. `fs_to_ds_valid` rises in cycle 1 with bus = {rdata, 32'h1c000000}.
- Stall hold:
  - Stimulus: `block_if` high for 3 cycles while IF holds pc 1c000008. rdata is changed to junk after the first cycle.
  - Required: `en = 0`, `fs_to_ds_valid = 0`, and the bus inst keeps the original word.
  - Required on release: the bus emits pc 1c000008 with the original inst, then pc 1c00000c.
- Taken branch:
  - Stimulus: `br_taken = 1`, target 1c000100, with IF at pc 1c000010.
  - Required: `fs_to_ds_valid = 0` that cycle and `addr = 1c000100`. The next valid bus pc is 1c000100; pc 1c000010 never appears.
- Unresolved branch:
  - Stimulus: `br_taken = 1` with `br_stall = block_if = 1` for 2 cycles, then `br_stall = block_if = 0`.
  - Required: no redirect while `br_stall` is high. Exactly one redirect, then `addr = target`.
- Branch with ID blocked:
  - Stimulus: `br_taken = 1`, `ds_allowin = 0` for 2 cycles, then 1.
  - Required: the redirect fires only in the cycle `ds_allowin` goes high. A single fetch of the target occurs.
- Reset mid-stall:
  - Stimulus: resetn low for one cycle while `inst_buf_valid = 1`.
  - Required: next cycle `fs_valid = 0`, `inst_buf_valid = 0`. The first fetch after release is again 1c000000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - IF-stage bundle: ID handshake, hazard/branch inputs, instruction SRAM port
// Ports (master = fetch stage side):
//   ds_allowin, block_if, br_stall, br_taken, br_target   in  to fetch
//   fs_to_ds_valid, fs_to_ds_bus {inst, pc}               out to ID
//   inst_sram_en/we/addr/wdata out, inst_sram_rdata in    instruction SRAM
interface fetch_stage_if;
    logic        ds_allowin;
    logic        block_if;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin, block_if, br_stall, br_taken, br_target, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, block_if, br_stall, br_taken, br_target, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, SRAM read issue, stall buffer, branch redirect
// Ports:
//   clk     pipeline clock
//   resetn  synchronous active-low reset
//   pipe    fetch_stage_if.master: ID handshake, hazard/branch inputs, instruction SRAM port
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic           clk,
    input  logic           resetn,
    fetch_stage_if.master  pipe
);

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;

    logic        redirect;
    logic        fs_allowin;
    logic [31:0] nextpc;
    logic [31:0] inst;

    always_comb begin
        // A branch redirects only in the cycle it leaves ID, so a held br_taken
        // produces a single redirect.
        redirect   = pipe.br_taken && !pipe.br_stall && pipe.ds_allowin;
        nextpc     = redirect ? pipe.br_target : (fs_pc + 32'd4);
        fs_allowin = !fs_valid || redirect || (pipe.ds_allowin && !pipe.block_if);
        // SRAM data is only valid the cycle after the read; later stalled
        // cycles must use the captured copy.
        inst       = inst_buf_valid ? inst_buf : pipe.inst_sram_rdata;
    end

    assign pipe.inst_sram_en    = resetn && fs_allowin;
    assign pipe.inst_sram_we    = 4'b0;
    assign pipe.inst_sram_addr  = nextpc;
    assign pipe.inst_sram_wdata = 32'b0;

    // The wrong-path instruction sitting in IF during a redirect is dropped.
    assign pipe.fs_to_ds_valid  = fs_valid && !redirect && !pipe.block_if;
    assign pipe.fs_to_ds_bus    = {inst, fs_pc};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid       <= 1'b0;
            fs_pc          <= RESET_PC - 32'd4;
            inst_buf       <= 32'b0;
            inst_buf_valid <= 1'b0;
        end else begin
            if (fs_allowin) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end
            // Clear wins over set; capture happens in the first stalled cycle.
            if (fs_allowin) begin
                inst_buf_valid <= 1'b0;
            end else if (fs_valid && !inst_buf_valid) begin
                inst_buf       <= pipe.inst_sram_rdata;
                inst_buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   transfers = 0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (bus)
    );

    always #5 clk = ~clk;

    // Program image: every address holds a distinct word derived from it.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
    endfunction

    // Synchronous SRAM; output is garbage whenever no read was issued, so any
    // reliance on stale rdata shows up.
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
        else
            bus.inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected program-order stream of {inst, pc} that ID must receive.
    logic [63:0] exp_q[$];
    logic [31:0] stream_pc = RST_PC;

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        stream_pc = pc;
    endtask

    // Applies the architectural rules to the inputs just driven, then keeps
    // the expected queue topped up with the sequential path.
    task automatic note_inputs();
        if (!resetn)
            restart_stream(RST_PC);
        else if (bus.br_taken && !bus.br_stall && bus.ds_allowin)
            restart_stream(bus.br_target);
        while (exp_q.size() < 8) begin
            exp_q.push_back({mem_word(stream_pc), stream_pc});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string name, input logic e_en, input logic [31:0] e_addr,
                                input logic e_valid, input logic chk_bus, input logic [31:0] e_pc);
        @(negedge clk);
        chk({name, "_en"}, 64'(bus.inst_sram_en), 64'(e_en));
        if (e_en) chk({name, "_addr"}, 64'(bus.inst_sram_addr), 64'(e_addr));
        chk({name, "_valid"}, 64'(bus.fs_to_ds_valid), 64'(e_valid));
        if (chk_bus) chk({name, "_bus"}, bus.fs_to_ds_bus, {mem_word(e_pc), e_pc});
    endtask

    // Monitor: pops the scoreboard on every accepted transfer.
    always @(negedge clk) begin
        if (resetn) begin
            chk("sram_we", 64'(bus.inst_sram_we), 64'd0);
            chk("sram_wdata", 64'(bus.inst_sram_wdata), 64'd0);
            if (bus.block_if)
                chk("valid_while_blocked", 64'(bus.fs_to_ds_valid), 64'd0);
            if (bus.br_taken && !bus.br_stall && bus.ds_allowin) begin
                chk("redirect_valid", 64'(bus.fs_to_ds_valid), 64'd0);
                chk("redirect_en", 64'(bus.inst_sram_en), 64'd1);
                chk("redirect_addr", 64'(bus.inst_sram_addr), 64'(bus.br_target));
            end
            if (bus.fs_to_ds_valid && bus.ds_allowin) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_underflow: got %h with no expected entry", bus.fs_to_ds_bus);
                end else begin
                    chk("stream", bus.fs_to_ds_bus, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ds_allowin = 1'b1;
        bus.block_if   = 1'b0;
        bus.br_stall   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'h0;
        resetn         = 1'b0;
        note_inputs();
        tick(); note_inputs();
        @(negedge clk);
        chk("reset_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        chk("reset_en", 64'(bus.inst_sram_en), 64'd0);
        chk("reset_buf_valid", 64'(dut.inst_buf_valid), 64'd0);

        // Reset release and sequential fetch
        tick(); resetn = 1'b1; note_inputs();
        expect_cycle("rel0", 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0);
        tick(); note_inputs();
        expect_cycle("rel1", 1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h1c000000);
        tick(); note_inputs();
        expect_cycle("rel2", 1'b1, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004);

        // Stall hold: IF at 1c000008 for three blocked cycles
        for (int i = 0; i < 3; i++) begin
            tick(); bus.block_if = 1'b1; note_inputs();
            expect_cycle("stall", 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000008);
        end
        tick(); bus.block_if = 1'b0; note_inputs();
        expect_cycle("stall_rel0", 1'b1, 32'h1c00000c, 1'b1, 1'b1, 32'h1c000008);
        tick(); note_inputs();
        expect_cycle("stall_rel1", 1'b1, 32'h1c000010, 1'b1, 1'b1, 32'h1c00000c);

        // Taken branch with IF at 1c000010
        tick(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000100; note_inputs();
        expect_cycle("br0", 1'b1, 32'h1c000100, 1'b0, 1'b0, 32'h0);
        tick(); bus.br_taken = 1'b0; note_inputs();
        expect_cycle("br1", 1'b1, 32'h1c000104, 1'b1, 1'b1, 32'h1c000100);

        // Unresolved branch: no redirect while br_stall is high
        for (int i = 0; i < 2; i++) begin
            tick(); bus.br_taken = 1'b1; bus.br_stall = 1'b1; bus.block_if = 1'b1;
            bus.br_target = 32'h1c000200; note_inputs();
            expect_cycle("brstall", 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000104);
        end
        tick(); bus.br_stall = 1'b0; bus.block_if = 1'b0; note_inputs();
        expect_cycle("brstall_rel", 1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h0);
        tick(); bus.br_taken = 1'b0; note_inputs();
        expect_cycle("brstall_tgt", 1'b1, 32'h1c000204, 1'b1, 1'b1, 32'h1c000200);

        // Branch deferred while ID cannot accept
        for (int i = 0; i < 2; i++) begin
            tick(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000300; bus.ds_allowin = 1'b0; note_inputs();
            expect_cycle("brdefer", 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000204);
        end
        tick(); bus.ds_allowin = 1'b1; note_inputs();
        expect_cycle("brdefer_fire", 1'b1, 32'h1c000300, 1'b0, 1'b0, 32'h0);
        tick(); bus.br_taken = 1'b0; note_inputs();
        expect_cycle("brdefer_tgt", 1'b1, 32'h1c000304, 1'b1, 1'b1, 32'h1c000300);

        // PC wraps modulo 2^32
        tick(); bus.br_taken = 1'b1; bus.br_target = 32'hfffffff8; note_inputs();
        expect_cycle("wrap0", 1'b1, 32'hfffffff8, 1'b0, 1'b0, 32'h0);
        tick(); bus.br_taken = 1'b0; note_inputs();
        expect_cycle("wrap1", 1'b1, 32'hfffffffc, 1'b1, 1'b1, 32'hfffffff8);
        tick(); note_inputs();
        expect_cycle("wrap2", 1'b1, 32'h00000000, 1'b1, 1'b1, 32'hfffffffc);
        tick(); note_inputs();
        expect_cycle("wrap3", 1'b1, 32'h00000004, 1'b1, 1'b1, 32'h00000000);

        // Reset in the middle of a stall with the buffer holding data
        tick(); bus.block_if = 1'b1; note_inputs();
        expect_cycle("rststall0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000004);
        tick(); note_inputs();
        @(negedge clk);
        chk("rststall_buf_set", 64'(dut.inst_buf_valid), 64'd1);
        tick(); resetn = 1'b0; note_inputs();
        @(negedge clk);
        chk("rststall_en", 64'(bus.inst_sram_en), 64'd0);
        tick(); resetn = 1'b1; bus.block_if = 1'b0; note_inputs();
        @(negedge clk);
        chk("rststall_fs_valid", 64'(dut.fs_valid), 64'd0);
        chk("rststall_buf_clr", 64'(dut.inst_buf_valid), 64'd0);
        chk("rststall_addr", 64'(bus.inst_sram_addr), 64'(RST_PC));
        chk("rststall_out", 64'(bus.fs_to_ds_valid), 64'd0);
        tick(); note_inputs();
        expect_cycle("rststall_first", 1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h1c000000);

        // Random traffic, checked by the scoreboard and monitor invariants
        for (int i = 0; i < 3000; i++) begin
            tick();
            resetn        = ($urandom_range(0, 299) != 0);
            bus.ds_allowin = ($urandom_range(0, 9) < 8);
            bus.br_stall  = ($urandom_range(0, 9) == 0);
            bus.block_if  = bus.br_stall || ($urandom_range(0, 9) < 2);
            bus.br_taken  = ($urandom_range(0, 9) < 2);
            bus.br_target = ($urandom_range(0, 19) == 0) ? 32'hfffffff8
                          : (RST_PC + ($urandom_range(0, 1023) << 2));
            note_inputs();
        end
        tick();
        resetn = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_stall = 1'b0;
        bus.block_if = 1'b0;
        note_inputs();
        @(negedge clk);
        chk("enough_transfers", 64'(transfers > 800), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
